// File: rtl/sprite_pkg.sv
// Shared sprite ROM geometry, requester ids and the response tag layout
// used by the sprite ROM arbiter and its address calculator.
package sprite_pkg;

   localparam int SPR_W   = 30;
   localparam int SPR_H   = 30;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 16;
   localparam int COORD_W = 5;
   localparam int NUM_REQ = 2;

   typedef enum logic {
      REQ_DISP = 1'b0,
      REQ_COLL = 1'b1
   } req_id_t;

   typedef struct packed {
      logic    vld;
      req_id_t id;
      logic    oob;
   } rsp_tag_t;

   function automatic req_id_t other_req(input req_id_t id);
      return (id == REQ_DISP) ? REQ_COLL : REQ_DISP;
   endfunction

endpackage

// File: rtl/sprite_addr_calc.sv
// Linear sprite ROM address (row-major, y*SPR_W + x) and out-of-range flag.
module sprite_addr_calc
   import sprite_pkg::*;
#(
   parameter int SPR_W   = sprite_pkg::SPR_W,
   parameter int SPR_H   = sprite_pkg::SPR_H,
   parameter int ADDR_W  = sprite_pkg::ADDR_W,
   parameter int COORD_W = sprite_pkg::COORD_W
)(
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [ADDR_W-1:0]  addr,
   output logic               oob
);

   logic [ADDR_W-1:0] xe;
   logic [ADDR_W-1:0] ye;

   assign xe = ADDR_W'(x);
   assign ye = ADDR_W'(y);

   // Constant multiplier folds to shift-subtract, e.g. (y<<5)-(y<<1) for 30.
   assign addr = (ye * ADDR_W'(SPR_W)) + xe;
   assign oob  = (int'(x) >= SPR_W) || (int'(y) >= SPR_H);

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port sprite ROM with
// one-cycle read latency; responses are steered back by a one-stage tag.
module sprite_rom_arbiter
   import sprite_pkg::*;
#(
   parameter int SPR_W  = sprite_pkg::SPR_W,
   parameter int SPR_H  = sprite_pkg::SPR_H,
   parameter int ADDR_W = sprite_pkg::ADDR_W,
   parameter int DATA_W = sprite_pkg::DATA_W
)(
   input  logic              clka,
   input  logic              rsta,
   input  logic              req0,
   input  logic              req1,
   input  logic [4:0]        x0,
   input  logic [4:0]        y0,
   input  logic [4:0]        x1,
   input  logic [4:0]        y1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              err0,
   output logic              err1,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rst,
   input  logic [DATA_W-1:0] rom_doa
);

   logic [NUM_REQ-1:0]              req;
   logic [NUM_REQ-1:0]              gnt;
   logic [NUM_REQ-1:0]              rvalid;
   logic [NUM_REQ-1:0]              err;
   logic [NUM_REQ-1:0][DATA_W-1:0]  rdata;
   logic [COORD_W-1:0]              win_x;
   logic [COORD_W-1:0]              win_y;
   logic [ADDR_W-1:0]               calc_addr;
   logic [ADDR_W-1:0]               addr_q;
   logic                            calc_oob;
   logic                            any_gnt;
   req_id_t                         prio;
   req_id_t                         win;
   rsp_tag_t                        tag;

   assign req = {req1, req0};

   always_comb begin
      gnt = '0;
      if (!rsta) begin
         if (req[0] && (!req[1] || prio == REQ_DISP))
            gnt[0] = 1'b1;
         else if (req[1])
            gnt[1] = 1'b1;
      end
   end

   assign any_gnt = |gnt;
   assign win     = gnt[1] ? REQ_COLL : REQ_DISP;
   assign win_x   = gnt[1] ? x1 : x0;
   assign win_y   = gnt[1] ? y1 : y0;

   sprite_addr_calc #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .ADDR_W  (ADDR_W),
      .COORD_W (COORD_W)
   ) u_calc (
      .x    (win_x),
      .y    (win_y),
      .addr (calc_addr),
      .oob  (calc_oob)
   );

   // An out-of-range grant never touches the ROM, so the bus keeps its last address.
   assign rom_addr = rsta                     ? '0 :
                     (any_gnt && !calc_oob)   ? calc_addr : addr_q;
   assign rom_rst  = rsta;

   always_ff @(posedge clka) begin
      if (rsta) begin
         prio   <= REQ_DISP;
         addr_q <= '0;
         tag    <= '0;
      end else begin
         tag <= '{vld: any_gnt, id: win, oob: calc_oob};
         if (any_gnt) begin
            prio <= other_req(win);
            if (!calc_oob)
               addr_q <= calc_addr;
         end
      end
   end

   // The rsta gate drops a tag captured in the cycle just before reset.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
      assign rvalid[i] = !rsta && tag.vld && (int'(tag.id) == i);
      assign err[i]    = rvalid[i] && tag.oob;
      assign rdata[i]  = (rvalid[i] && !tag.oob) ? rom_doa : '0;
   end

   assign gnt0    = gnt[0];
   assign gnt1    = gnt[1];
   assign rvalid0 = rvalid[0];
   assign rvalid1 = rvalid[1];
   assign err0    = err[0];
   assign err1    = err[1];
   assign rdata0  = rdata[0];
   assign rdata1  = rdata[1];

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios plus a per-cycle reference
// model whose expected responses are queued at grant and popped on rvalid.
module tb_sprite_rom_arbiter;

   logic        clka = 1'b0;
   logic        rsta = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [4:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, rom_rst;
   logic [15:0] rdata0, rdata1;
   logic [15:0] rom_doa = '0;
   logic [9:0]  rom_addr;

   int errors = 0;
   int checks = 0;

   sprite_rom_arbiter dut (
      .clka(clka), .rsta(rsta),
      .req0(req0), .req1(req1),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1),
      .rom_addr(rom_addr), .rom_rst(rom_rst),
      .rom_doa(rom_doa)
   );

   always #5 clka = ~clka;

   function automatic logic [15:0] rom_f(input logic [9:0] a);
      return {a[5:0], a} ^ 16'hA55A;
   endfunction

   // Sprite ROM model: one cycle read latency.
   always @(posedge clka) rom_doa <= rom_f(rom_addr);

   // ---------------- reference model / scoreboard ----------------
   typedef struct packed {
      logic       id;
      logic       oob;
      logic [9:0] addr;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic        m_prio = 1'b0;
   logic [9:0]  m_addr = '0;
   logic        due    = 1'b0;
   logic        eg0, eg1, eoob;
   logic [4:0]  ex, ey;
   logic [9:0]  ea, erom;
   logic [15:0] erd;
   int          w0 = 0, w1 = 0;

   always @(negedge clka) begin
      if (rsta) begin
         checks++;
         if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1} !== 6'b0 || rdata0 !== 16'h0 ||
             rdata1 !== 16'h0 || rom_addr !== 10'h0 || rom_rst !== 1'b1) begin
            errors++;
            $display("FAIL mon_reset: gnt=%b%b rvalid=%b%b err=%b%b rdata=%h/%h addr=%0d rom_rst=%b, required all 0 and rom_rst=1",
                     gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1, rom_addr, rom_rst);
         end
         m_prio = 1'b0; m_addr = '0; due = 1'b0; sb.delete(); w0 = 0; w1 = 0;
      end else begin
         checks++;
         if (due) begin
            e   = sb.pop_front();
            erd = e.oob ? 16'h0 : rom_f(e.addr);
            if (rvalid0 !== (e.id == 1'b0) || rvalid1 !== (e.id == 1'b1) ||
                (e.id == 1'b0 && (rdata0 !== erd || err0 !== e.oob || rdata1 !== 16'h0 || err1 !== 1'b0)) ||
                (e.id == 1'b1 && (rdata1 !== erd || err1 !== e.oob || rdata0 !== 16'h0 || err0 !== 1'b0))) begin
               errors++;
               $display("FAIL mon_rsp: rvalid=%b%b rdata=%h/%h err=%b%b, required id=%0d rdata=%h err=%b",
                        rvalid0, rvalid1, rdata0, rdata1, err0, err1, e.id, erd, e.oob);
            end
         end else if ({rvalid0, rvalid1, err0, err1} !== 4'b0 || rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
            errors++;
            $display("FAIL mon_idle: rvalid=%b%b err=%b%b rdata=%h/%h, required all 0",
                     rvalid0, rvalid1, err0, err1, rdata0, rdata1);
         end

         eg0  = req0 && (!req1 || m_prio == 1'b0);
         eg1  = req1 && !eg0;
         ex   = eg1 ? x1 : x0;
         ey   = eg1 ? y1 : y0;
         eoob = (ex >= 5'd30) || (ey >= 5'd30);
         ea   = 10'(int'(ey) * 30 + int'(ex));
         erom = ((eg0 || eg1) && !eoob) ? ea : m_addr;
         checks++;
         if (gnt0 !== eg0 || gnt1 !== eg1 || rom_addr !== erom) begin
            errors++;
            $display("FAIL mon_gnt: gnt=%b%b rom_addr=%0d, required gnt=%b%b rom_addr=%0d",
                     gnt0, gnt1, rom_addr, eg0, eg1, erom);
         end
         if (eg0 || eg1) begin
            sb.push_back('{id: eg1, oob: eoob, addr: ea});
            due    = 1'b1;
            m_prio = !eg1;
            if (!eoob) m_addr = ea;
         end else begin
            due = 1'b0;
         end

         w0 = (req0 && !gnt0) ? w0 + 1 : 0;
         w1 = (req1 && !gnt1) ? w1 + 1 : 0;
         if (req0 || req1) begin
            checks++;
            if (w0 > 1 || w1 > 1) begin
               errors++;
               $display("FAIL mon_starve: wait0=%0d wait1=%0d, required <= 1", w0, w1);
            end
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic next_cycle();
      @(posedge clka);
      #1;
   endtask

   task automatic do_reset();
      rsta = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      next_cycle();
      next_cycle();
      rsta = 1'b0;
   endtask

   task automatic test_reset();
      rsta = 1'b1;
      req0 = 1'b1; req1 = 1'b1; x0 = 5'd3; y0 = 5'd2;
      next_cycle();
      @(negedge clka);
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid0 !== 1'b0 || rom_addr !== 10'd0) begin
         errors++;
         $display("FAIL reset: gnt=%b%b rvalid0=%b rom_addr=%0d, required 0 0 0 0", gnt0, gnt1, rvalid0, rom_addr);
      end
      do_reset();
   endtask

   task automatic test_single();
      req0 = 1'b1; x0 = 5'd3; y0 = 5'd2;
      @(negedge clka);
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || rom_addr !== 10'd63) begin
         errors++;
         $display("FAIL single_gnt: gnt=%b%b rom_addr=%0d, required gnt=10 rom_addr=63", gnt0, gnt1, rom_addr);
      end
      next_cycle();
      req0 = 1'b0;
      @(negedge clka);
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== rom_f(10'd63) || err0 !== 1'b0) begin
         errors++;
         $display("FAIL single_rsp: rvalid0=%b rdata0=%h err0=%b, required 1 %h 0", rvalid0, rdata0, err0, rom_f(10'd63));
      end
      next_cycle();
   endtask

   task automatic test_alternate();
      logic [9:0] a;
      do_reset();
      req0 = 1'b1; x0 = 5'd1; y0 = 5'd1;
      req1 = 1'b1; x1 = 5'd2; y1 = 5'd3;
      for (int k = 0; k < 6; k++) begin
         @(negedge clka);
         a = (k % 2 == 0) ? 10'd31 : 10'd92;
         checks++;
         if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1) || rom_addr !== a) begin
            errors++;
            $display("FAIL alternate_gnt[%0d]: gnt=%b%b rom_addr=%0d, required gnt0=%b rom_addr=%0d",
                     k, gnt0, gnt1, rom_addr, (k % 2 == 0), a);
         end
         if (k > 0) begin
            checks++;
            if (rvalid0 !== (k % 2 == 1) || rvalid1 !== (k % 2 == 0)) begin
               errors++;
               $display("FAIL alternate_rsp[%0d]: rvalid=%b%b, required rvalid0=%b", k, rvalid0, rvalid1, (k % 2 == 1));
            end
         end
         next_cycle();
      end
      req0 = 1'b0; req1 = 1'b0;
      next_cycle();
   endtask

   task automatic test_bounds();
      req1 = 1'b1; x1 = 5'd29; y1 = 5'd29;
      @(negedge clka);
      checks++;
      if (gnt1 !== 1'b1 || rom_addr !== 10'd899) begin
         errors++;
         $display("FAIL bounds_max: gnt1=%b rom_addr=%0d, required 1 899", gnt1, rom_addr);
      end
      next_cycle();
      x1 = 5'd30; y1 = 5'd0;
      @(negedge clka);
      checks++;
      if (gnt1 !== 1'b1 || rom_addr !== 10'd899 || rvalid1 !== 1'b1 || rdata1 !== rom_f(10'd899)) begin
         errors++;
         $display("FAIL bounds_oob_gnt: gnt1=%b rom_addr=%0d rvalid1=%b rdata1=%h, required 1 899 1 %h",
                  gnt1, rom_addr, rvalid1, rdata1, rom_f(10'd899));
      end
      next_cycle();
      req1 = 1'b0;
      @(negedge clka);
      checks++;
      if (rvalid1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 16'h0 || rom_addr !== 10'd899) begin
         errors++;
         $display("FAIL bounds_oob_rsp: rvalid1=%b err1=%b rdata1=%h rom_addr=%0d, required 1 1 0 899",
                  rvalid1, err1, rdata1, rom_addr);
      end
      next_cycle();
   endtask

   task automatic test_reset_inflight();
      req0 = 1'b1; x0 = 5'd5; y0 = 5'd4;
      @(negedge clka);
      checks++;
      if (gnt0 !== 1'b1) begin
         errors++;
         $display("FAIL inflight_gnt: gnt0=%b, required 1", gnt0);
      end
      next_cycle();
      rsta = 1'b1; req0 = 1'b0;
      @(negedge clka);
      checks++;
      if (rvalid0 !== 1'b0 || rdata0 !== 16'h0) begin
         errors++;
         $display("FAIL inflight_drop: rvalid0=%b rdata0=%h, required 0 0", rvalid0, rdata0);
      end
      next_cycle();
      rsta = 1'b0;
      req0 = 1'b1; req1 = 1'b1; x1 = 5'd7; y1 = 5'd1;
      @(negedge clka);
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_prio: gnt=%b%b, required 10", gnt0, gnt1);
      end
      next_cycle();
      req0 = 1'b0; req1 = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_random(input int n);
      logic g0, g1;
      int ngnt = 0, nrsp = 0;
      for (int c = 0; c < n + 3; c++) begin
         @(negedge clka);
         g0 = gnt0; g1 = gnt1;
         ngnt += int'(gnt0) + int'(gnt1);
         nrsp += int'(rvalid0) + int'(rvalid1);
         checks++;
         if (g0 && g1) begin
            errors++;
            $display("FAIL random_double_gnt: cycle %0d", c);
         end
         next_cycle();
         if (c >= n) begin
            req0 = 1'b0; req1 = 1'b0;
         end else begin
            if (!req0 || g0) begin
               req0 = ($urandom_range(0, 3) != 0);
               x0   = 5'($urandom_range(0, 31));
               y0   = 5'($urandom_range(0, 31));
            end
            if (!req1 || g1) begin
               req1 = ($urandom_range(0, 2) != 0);
               x1   = 5'($urandom_range(0, 31));
               y1   = 5'($urandom_range(0, 31));
            end
         end
      end
      checks++;
      if (ngnt !== nrsp || ngnt == 0) begin
         errors++;
         $display("FAIL random_count: grants=%0d responses=%0d, required equal and nonzero", ngnt, nrsp);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_bounds();
      test_reset_inflight();
      test_random(10000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
